// File: rtl/scan_decoder.sv
// Registered binary-to-one-hot decoder with enable and an auto-scan mode that
// steps the active output with a programmable dwell and wrap point.
// Optional blanking gap before each scan advance: define SCAN_DECODER_BLANK_EN.
module scan_decoder #(
    parameter int SEL_W = 3,
    parameter int DWELL = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      x,
    input  logic                  x_valid,
    input  logic [SEL_W-1:0]      scan_last,
    output logic [2**SEL_W-1:0]   D,
    output logic [SEL_W-1:0]      idx,
    output logic                  step
);

    localparam int OUT_N = 2**SEL_W;
    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL - 1);

    generate
        if (SEL_W < 1) begin : g_sel_check
            $error("scan_decoder: SEL_W must be >= 1");
        end
        if (DWELL < 1) begin : g_dwell_check
            $error("scan_decoder: DWELL must be >= 1");
        end
`ifdef SCAN_DECODER_BLANK_EN
        if (DWELL < 2) begin : g_blank_check
            $error("scan_decoder: DWELL must be >= 2 when blanking is enabled");
        end
`endif
    endgenerate

    logic [OUT_N-1:0] d_q,    d_d;
    logic [SEL_W-1:0] idx_q,  idx_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;
    logic             step_q, step_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            d_q    <= '0;
            idx_q  <= '0;
            cnt_q  <= '0;
            step_q <= 1'b0;
        end else begin
            d_q    <= d_d;
            idx_q  <= idx_d;
            cnt_q  <= cnt_d;
            step_q <= step_d;
        end
    end

    // D is decoded from the index being loaded this edge, so it never lags idx.
    always_comb begin
        idx_d  = idx_q;
        cnt_d  = '0;
        step_d = 1'b0;
        d_d    = '0;
        if (en) begin
            if (!mode) begin
                if (x_valid) begin
                    idx_d  = x;
                    step_d = (x != idx_q);
                end
            end else if (cnt_q == LAST_CNT) begin
                // Out-of-range indices wrap to 0 at the advance edge as well.
                idx_d  = (idx_q >= scan_last) ? '0 : idx_q + SEL_W'(1);
                step_d = (idx_d != idx_q);
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            d_d = OUT_N'(1) << idx_d;
`ifdef SCAN_DECODER_BLANK_EN
            if (mode && cnt_d == LAST_CNT) begin
                d_d = '0;
            end
`endif
        end
    end

    assign D    = d_q;
    assign idx  = idx_q;
    assign step = step_q;

endmodule

// File: tb/tb_scan_decoder.sv
// Directed self-checking bench for scan_decoder (SEL_W=3, DWELL=4); expected
// values follow the blanking option when SCAN_DECODER_BLANK_EN is defined.
module tb_scan_decoder;

    localparam int SEL_W = 3;
    localparam int DWELL = 4;

`ifdef SCAN_DECODER_BLANK_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic             mode;
    logic [SEL_W-1:0] x;
    logic             x_valid;
    logic [SEL_W-1:0] scan_last;
    logic [7:0]       D;
    logic [SEL_W-1:0] idx;
    logic             step;

    int vectors = 0;
    int miscompares = 0;

    scan_decoder #(.SEL_W(SEL_W), .DWELL(DWELL)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .mode      (mode),
        .x         (x),
        .x_valid   (x_valid),
        .scan_last (scan_last),
        .D         (D),
        .idx       (idx),
        .step      (step)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic r, input logic e, input logic m,
                                 input logic [SEL_W-1:0] xv, input logic s,
                                 input logic [SEL_W-1:0] last);
        rst_n     = r;
        en        = e;
        mode      = m;
        x         = xv;
        x_valid   = s;
        scan_last = last;
        tick();
    endtask

    task automatic checkOne(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] expD,
                               input logic [SEL_W-1:0] expIdx, input logic expStep);
        checkOne({tag, ".D"},    32'(D),    32'(expD));
        checkOne({tag, ".idx"},  32'(idx),  32'(expIdx));
        checkOne({tag, ".step"}, 32'(step), 32'(expStep));
    endtask

    initial begin
        logic [SEL_W-1:0] eIdx;
        logic [7:0]       eD;

        // Reset held with a live load request must keep everything cleared.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 3'd5, 1'b1, 3'd0);
            checkOutput("reset", 8'h00, 3'd0, 1'b0);
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 3'd5, 1'b1, 3'd0);
        checkOutput("release_load5", 8'h20, 3'd5, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, 3'd5, 1'b0, 3'd0);
        checkOutput("hold5", 8'h20, 3'd5, 1'b0);

        applyStimulus(1'b1, 1'b1, 1'b0, 3'd3, 1'b1, 3'd0);
        checkOutput("load3", 8'h08, 3'd3, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, 3'd3, 1'b1, 3'd0);
        checkOutput("reload3", 8'h08, 3'd3, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 3'd7, 1'b1, 3'd0);
        checkOutput("load7", 8'h80, 3'd7, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, 3'd2, 1'b0, 3'd0);
        checkOutput("novalid", 8'h80, 3'd7, 1'b0);

        applyStimulus(1'b1, 1'b1, 1'b0, 3'd3, 1'b1, 3'd0);
        checkOutput("load3b", 8'h08, 3'd3, 1'b1);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 3'd6, 1'b1, 3'd0);
            checkOutput("en_off", 8'h00, 3'd3, 1'b0);
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 3'd6, 1'b0, 3'd0);
        checkOutput("en_on", 8'h08, 3'd3, 1'b0);

        // Scan 0..2 with dwell 4; the load edge is the first cycle of index 0.
        applyStimulus(1'b1, 1'b1, 1'b0, 3'd0, 1'b1, 3'd2);
        checkOutput("load0", 8'h01, 3'd0, 1'b1);
        for (int k = 1; k <= 16; k++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 3'd2);
            eIdx = SEL_W'((k / 4) % 3);
            eD   = (BLANK && (k % 4 == 3)) ? 8'h00 : 8'(1 << eIdx);
            checkOutput($sformatf("scan%0d", k), eD, eIdx, (k % 4 == 0));
        end

        // Two more edges leave cnt=2 on index 1, then reset mid-dwell.
        applyStimulus(1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 3'd2);
        applyStimulus(1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 3'd2);
        checkOutput("middwell", 8'h02, 3'd1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 3'd2);
        checkOutput("midreset", 8'h00, 3'd0, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 3'd2);
            eIdx = (k == 4) ? 3'd1 : 3'd0;
            eD   = (BLANK && k == 3) ? 8'h00 : 8'(1 << eIdx);
            checkOutput($sformatf("restart%0d", k), eD, eIdx, (k == 4));
        end

        // Index above scan_last dwells fully, then wraps to 0.
        applyStimulus(1'b1, 1'b1, 1'b0, 3'd7, 1'b1, 3'd2);
        checkOutput("load7b", 8'h80, 3'd7, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 3'd2);
            eIdx = (k == 4) ? 3'd0 : 3'd7;
            eD   = (BLANK && k == 3) ? 8'h00 : 8'(1 << eIdx);
            checkOutput($sformatf("oor%0d", k), eD, eIdx, (k == 4));
        end
        applyStimulus(1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 3'd2);
        checkOutput("oor_after", 8'h01, 3'd0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 3'd5, 1'b0, 3'd2);
            checkOutput("to_direct", 8'h01, 3'd0, 1'b0);
        end

        // scan_last=0 keeps index 0 with no step across two full dwells.
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 3'd0);
            eD = (BLANK && (k % 4 == 3)) ? 8'h00 : 8'h01;
            checkOutput($sformatf("last0_%0d", k), eD, 3'd0, 1'b0);
        end

        // en=0 dominates scan mode; re-enabling restarts the dwell from 0.
        applyStimulus(1'b1, 1'b0, 1'b1, 3'd0, 1'b1, 3'd2);
        checkOutput("scan_en_off", 8'h00, 3'd0, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 3'd2);
            eIdx = (k == 4) ? 3'd1 : 3'd0;
            eD   = (BLANK && k == 3) ? 8'h00 : 8'(1 << eIdx);
            checkOutput($sformatf("scan_en_on%0d", k), eD, eIdx, (k == 4));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
